// File: rtl/division_controller.sv
// Sequencer for an n-bit shift/subtract divider: operand handshake, start/shift/load/out
// strobes to the datapath, and a result handshake with an up-front divide-by-zero bypass.
module division_controller #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] divisor,
  input  logic [DATA_W-1:0] dividend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              div_by_zero,
  output logic              busy,
  output logic              dp_start,
  output logic              dp_shift,
  output logic              dp_load,
  output logic              dp_out,
  output logic [DATA_W-1:0] dp_divisor,
  output logic [DATA_W-1:0] dp_dividend
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_div_by_zero;
  logic               r_busy;
  logic               r_dp_start;
  logic               r_dp_shift;
  logic               r_dp_load;
  logic               r_dp_out;
  logic [DATA_W-1:0]  r_divisor;
  logic [DATA_W-1:0]  r_dividend;

  // Every output is set together with the state it belongs to, so all are plain flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_busy        <= 1'b0;
      r_dp_start    <= 1'b0;
      r_dp_shift    <= 1'b0;
      r_dp_load     <= 1'b0;
      r_dp_out      <= 1'b0;
      r_divisor     <= '0;
      r_dividend    <= '0;
    end else begin
      r_dp_start <= 1'b0;
      r_dp_shift <= 1'b0;
      r_dp_load  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_divisor  <= divisor;
            r_dividend <= dividend;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (divisor == '0) begin
              r_state       <= S_DONE;
              r_div_by_zero <= 1'b1;
              r_out_valid   <= 1'b1;
            end else begin
              r_state    <= S_INIT;
              r_dp_start <= 1'b1;
            end
          end
        end
        S_INIT: begin
          r_state    <= S_SHIFT;
          r_dp_shift <= 1'b1;
        end
        S_SHIFT: begin
          r_state   <= S_LOAD;
          r_dp_load <= 1'b1;
        end
        S_LOAD: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_dp_out    <= 1'b1;
          end else begin
            r_state    <= S_SHIFT;
            r_dp_shift <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state       <= S_IDLE;
            r_out_valid   <= 1'b0;
            r_dp_out      <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign div_by_zero = r_div_by_zero;
  assign busy        = r_busy;
  assign dp_start    = r_dp_start;
  assign dp_shift    = r_dp_shift;
  assign dp_load     = r_dp_load;
  assign dp_out      = r_dp_out;
  assign dp_divisor  = r_divisor;
  assign dp_dividend = r_dividend;

endmodule
